csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Machine-mode CSR file and trap sequencer for the RV32I pipeline.
- Serves the CSR read value to the EX stage, where it becomes the z_ operand for the EX control block.
- Takes the ALU-computed new CSR value back from WB.
- Sequences ecall/mret state changes and drives the redirect target for the branch/PC logic.

Parameters:
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset
- MHARTID, 32'h0000_0000, value returned by mhartid

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  12  CSR address of instruction in EX (instr[31:20])
- rd_data  out  32  CSR read value, combinational from rd_addr (to EX z_)
- rd_illegal  out  1  rd_addr not implemented, combinational
- wr_en  in  1  CSR write from WB (csrrw/csrrs/csrrc/imm forms, rd_addr field nonzero-write rules applied upstream)
- wr_addr  in  12  CSR address of instruction in WB
- wr_data  in  32  new CSR value (ALU result)
- ecall  in  1  ecall retiring in WB this cycle
- mret  in  1  mret retiring in WB this cycle
- trap_pc  in  32  PC of the ecall instruction
- instr_retired  in  1  one instruction retires this cycle
- redirect_pc  out  32  target PC: mtvec base on ecall, mepc on mret, combinational

Behaviour:
Implemented CSRs, with their reset values:
- mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11, all other bits read 0. Reset: MIE=0, MPIE=0.
- mscratch 0x340. Reset 0.
- mtvec 0x305. Bits[1:0] hardwired 0 (direct mode only). Reset MTVEC_RESET with [1:0] forced 0.
- mepc 0x341. Bit[1:0] hardwired 0. Reset 0.
- mcause 0x342. Reset 0.
- mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82. Reset 0.
- Read-only shadows: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
- mhartid 0xF14: returns MHARTID, read-only.

Outputs at reset:
- rd_data and redirect_pc follow the reset register values.
- rd_illegal follows rd_addr.

Read port:
- Purely combinational; rd_data=0 and rd_illegal=1 for unimplemented addresses.
- No write bypass: a WB write lands at the clock edge, and same-cycle reads see the old value. Hazard forwarding is outside this block.

Write port:
- Writes take effect at the rising clock edge when wr_en=1.
- Writes to read-only or unimplemented addresses are silently dropped.
- Hardwired bits ignore written values.

ecall (edge):
- mepc <= trap_pc & ~3
- mcause <= 32'd11
- MPIE <= MIE
- MIE <= 0
- redirect_pc = mtvec same cycle.

mret (edge):
- MIE <= MPIE
- MPIE <= 1
- redirect_pc = mepc same cycle.

Priority and simultaneous events:
- ecall > mret (mret ignored when both are asserted).
- When ecall or mret is asserted, wr_en is ignored for mstatus, mepc and mcause. Writes to other CSRs proceed.
- When neither is asserted, redirect_pc = mtvec (don't-care to consumer).

Counters:
- mcycle: 64-bit, +1 every cycle.
- minstret: 64-bit, +1 on instr_retired.
- Both wrap from 2^64-1 to 0.
- A write to the low or high half that cycle replaces that half with wr_data and suppresses the increment for the whole counter that cycle. The other half is held.
- Carry from low to high is within the same edge.

Reset:
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous), regardless of pending wr_en/ecall/mret.
- First increment of mcycle occurs at the first rising edge after rst_n deasserts.

Decomposition:
- Shared header constants/csr_addr.v: CSR address defines (MSTATUS, MTVEC, MEPC, MCAUSE, MSCRATCH, MCYCLE, MCYCLEH, MINSTRET, MINSTRETH, CYCLE, CYCLEH, INSTRET, INSTRETH, MHARTID).
- Shared header constants/mcause.v: cause codes (ECALL_M = 11).
- Sub-module csr_counter64, instantiated twice (mcycle, minstret).
  - Inputs: clk, rst_n, inc, wr_lo, wr_hi, wr_data.
  - Outputs: value[63:0].
  - Behaviour: 64-bit counter with half-word write that blocks the increment.

Test Plan:
- Reset release, idle 5 cycles -> rd_addr=0xB00 reads 5; rd_addr=0x305 reads MTVEC_RESET; rd_addr=0x7C0 gives rd_data=0, rd_illegal=1.
- Write mtvec 0x0000_0103, then ecall with trap_pc=0x0000_0040 and MIE=1 -> redirect_pc=0x100 that cycle; then mepc=0x40, mcause=11, mstatus=0x0000_1880.
- mret after that ecall -> redirect_pc=0x40; then mstatus=0x0000_1888.
- Same cycle: ecall plus wr_en to mepc with 0xDEAD_BEEF -> mepc=trap_pc; same cycle: ecall plus wr_en to mscratch 0x1234 -> mscratch=0x1234.
- Write mcycle=0xFFFF_FFFF, then mcycleh=0xFFFF_FFFF on the next cycle -> following reads step through 0xFFFF_FFFF, then {mcycleh,mcycle} wraps to 0; write cycles show no increment.
- Write 0x55 to cycle (0xC00) and to mhartid -> both dropped, values unchanged; rst_n pulsed low mid-stream clears mepc/mscratch/counters asynchronously.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: CSR addresses, cause codes and alignment mask shared by the CSR file.
package csr_unit_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] ALIGN4        = 32'hFFFF_FFFC;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter; a half-word write replaces that half and blocks the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] value
);
  logic [63:0] r_value;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_value <= '0;
    else r_value <= wr_lo ? {r_value[63:32], wr_data} :
                    wr_hi ? {wr_data, r_value[31:0]} :
                    r_value + {63'd0, inc};
  assign value = r_value;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with ecall/mret trap sequencing and redirect target.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_illegal,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] trap_pc,
  input  logic        instr_retired,
  output logic [31:0] redirect_pc
);
  logic        r_mie, r_mpie;
  logic [31:0] r_mscratch, r_mtvec, r_mepc, r_mcause;
  logic [63:0] w_mcycle, w_minstret;
  logic        w_sys_wr;
  // trap sequencing owns mstatus/mepc/mcause on ecall or mret cycles
  assign w_sys_wr = wr_en && !ecall && !mret;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mscratch <= '0;
      r_mtvec    <= MTVEC_RESET & ALIGN4;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      if (ecall) begin
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mepc   <= trap_pc & ALIGN4;
        r_mcause <= CAUSE_ECALL_M;
      end else if (mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
      if (w_sys_wr && wr_addr == CSR_MSTATUS) begin
        r_mie  <= wr_data[3];
        r_mpie <= wr_data[7];
      end
      if (w_sys_wr && wr_addr == CSR_MEPC) r_mepc <= wr_data & ALIGN4;
      if (w_sys_wr && wr_addr == CSR_MCAUSE) r_mcause <= wr_data;
      if (wr_en && wr_addr == CSR_MSCRATCH) r_mscratch <= wr_data;
      if (wr_en && wr_addr == CSR_MTVEC) r_mtvec <= wr_data & ALIGN4;
    end
  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .wr_lo   (wr_en && wr_addr == CSR_MCYCLE),
    .wr_hi   (wr_en && wr_addr == CSR_MCYCLEH),
    .wr_data (wr_data),
    .value   (w_mcycle)
  );
  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (instr_retired),
    .wr_lo   (wr_en && wr_addr == CSR_MINSTRET),
    .wr_hi   (wr_en && wr_addr == CSR_MINSTRETH),
    .wr_data (wr_data),
    .value   (w_minstret)
  );
  always_comb begin
    rd_data    = '0;
    rd_illegal = 1'b0;
    case (rd_addr)
      CSR_MSTATUS:                  rd_data = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      CSR_MTVEC:                    rd_data = r_mtvec;
      CSR_MSCRATCH:                 rd_data = r_mscratch;
      CSR_MEPC:                     rd_data = r_mepc;
      CSR_MCAUSE:                   rd_data = r_mcause;
      CSR_MCYCLE, CSR_CYCLE:        rd_data = w_mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:      rd_data = w_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:    rd_data = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:  rd_data = w_minstret[63:32];
      CSR_MHARTID:                  rd_data = MHARTID;
      default:                      rd_illegal = 1'b1;
    endcase
  end
  assign redirect_pc = (mret && !ecall) ? r_mepc : r_mtvec;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checks of csr_unit against a behavioural CSR model.
module tb_csr_unit;
  localparam logic [31:0] MTV  = 32'h0000_0203;
  localparam logic [31:0] HART = 32'h0000_0005;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data, trap_pc, redirect_pc;
  logic        rd_illegal, wr_en, ecall, mret, instr_retired;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic        m_mie, m_mpie;
  logic [31:0] m_mscratch, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;
  logic [11:0] addrs [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h301};
  always #5 clk = ~clk;
  csr_unit #(.MTVEC_RESET(MTV), .MHARTID(HART)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ecall(ecall), .mret(mret),
    .trap_pc(trap_pc), .instr_retired(instr_retired), .redirect_pc(redirect_pc)
  );
  function automatic logic [32:0] mread(logic [11:0] a);
    case (a)
      12'h300: return {1'b0, 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7)};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'hB00, 12'hC00: return {1'b0, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_ins[63:32]};
      12'hF14: return {1'b0, HART};
      default: return {1'b1, 32'h0};
    endcase
  endfunction
  function automatic logic [63:0] next64(logic [63:0] v, logic inc, logic [11:0] lo, logic [11:0] hi);
    if (wr_en && wr_addr == lo) return {v[63:32], wr_data};
    if (wr_en && wr_addr == hi) return {wr_data, v[31:0]};
    return v + 64'(inc);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mie <= 1'b0; m_mpie <= 1'b0; m_mscratch <= '0; m_mtvec <= MTV & ~32'd3;
      m_mepc <= '0; m_mcause <= '0; m_cyc <= '0; m_ins <= '0;
    end else begin
      if (ecall) begin
        m_mepc <= trap_pc & ~32'd3; m_mcause <= 32'd11; m_mpie <= m_mie; m_mie <= 1'b0;
      end else if (mret) begin
        m_mie <= m_mpie; m_mpie <= 1'b1;
      end else if (wr_en) begin
        if (wr_addr == 12'h300) begin m_mie <= wr_data[3]; m_mpie <= wr_data[7]; end
        if (wr_addr == 12'h341) m_mepc <= wr_data & ~32'd3;
        if (wr_addr == 12'h342) m_mcause <= wr_data;
      end
      if (wr_en && wr_addr == 12'h340) m_mscratch <= wr_data;
      if (wr_en && wr_addr == 12'h305) m_mtvec <= wr_data & ~32'd3;
      m_cyc <= next64(m_cyc, 1'b1, 12'hB00, 12'hB80);
      m_ins <= next64(m_ins, instr_retired, 12'hB02, 12'hB82);
    end
  end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin : cmp
    logic [32:0] e;
    e = mread(rd_addr);
    chk("rd_data", rd_data, e[31:0]);
    chk("rd_illegal", {31'd0, rd_illegal}, {31'd0, e[32]});
    chk("redirect_pc", redirect_pc, (mret && !ecall) ? m_mepc : m_mtvec);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en = 1'b0; ecall = 1'b0; mret = 1'b0; instr_retired = 1'b0;
  endtask
  task automatic wr(logic [11:0] a, logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic rdchk(string n, logic [11:0] a, logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(n, rd_data, exp);
  endtask
  initial begin : main
    logic [31:0] v;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; trap_pc = '0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    rdchk("mtvec_in_reset", 12'h305, 32'h200);
    chk("redirect_in_reset", redirect_pc, 32'h200);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rdchk("mcycle_after_5", 12'hB00, 32'd5);
    rdchk("mtvec_reset", 12'h305, 32'h200);
    rdchk("unimpl_data", 12'h7C0, 32'h0);
    chk("unimpl_illegal", {31'd0, rd_illegal}, 32'd1);
    wr(12'h300, 32'h8);
    wr(12'h305, 32'h103);
    ecall = 1'b1; trap_pc = 32'h40;
    #1 chk("ecall_redirect", redirect_pc, 32'h100);
    tick();
    ecall = 1'b0;
    rdchk("ecall_mepc", 12'h341, 32'h40);
    rdchk("ecall_mcause", 12'h342, 32'd11);
    rdchk("ecall_mstatus", 12'h300, 32'h1880);
    mret = 1'b1;
    #1 chk("mret_redirect", redirect_pc, 32'h40);
    tick();
    mret = 1'b0;
    rdchk("mret_mstatus", 12'h300, 32'h1888);
    ecall = 1'b1; trap_pc = 32'h44; wr_en = 1'b1; wr_addr = 12'h341; wr_data = 32'hDEAD_BEEF;
    tick();
    idle();
    rdchk("ecall_blocks_mepc_wr", 12'h341, 32'h44);
    ecall = 1'b1; trap_pc = 32'h48; wr_en = 1'b1; wr_addr = 12'h340; wr_data = 32'h1234;
    tick();
    idle();
    rdchk("ecall_allows_mscratch", 12'h340, 32'h1234);
    wr_en = 1'b1; wr_addr = 12'hB00; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_addr = 12'hB80;
    rdchk("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
    tick();
    wr_en = 1'b0;
    rdchk("mcycle_lo_held", 12'hB00, 32'hFFFF_FFFF);
    rdchk("mcycle_hi_written", 12'hB80, 32'hFFFF_FFFF);
    tick();
    rdchk("mcycle_wrap_lo", 12'hB00, 32'h0);
    rdchk("mcycle_wrap_hi", 12'hB80, 32'h0);
    rd_addr = 12'hC00;
    #1 v = rd_data;
    wr(12'hC00, 32'h55);
    rdchk("cycle_write_dropped", 12'hC00, v + 32'd1);
    wr(12'hF14, 32'h55);
    rdchk("mhartid_write_dropped", 12'hF14, HART);
    wr(12'hB02, 32'h0);
    wr(12'hB82, 32'h0);
    instr_retired = 1'b1;
    repeat (3) tick();
    instr_retired = 1'b0;
    rdchk("minstret_3", 12'hB02, 32'd3);
    rdchk("instret_3", 12'hC02, 32'd3);
    for (int i = 0; i < 3000; i++) begin
      rd_addr = addrs[$urandom_range(0, 15)];
      wr_addr = addrs[$urandom_range(0, 15)];
      wr_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      wr_en = $urandom_range(0, 1) == 1;
      ecall = $urandom_range(0, 15) == 0;
      mret = $urandom_range(0, 15) == 0;
      trap_pc = $urandom;
      instr_retired = $urandom_range(0, 3) != 0;
      if (i == 1500) begin
        wr_en = 1'b1; wr_addr = 12'h340; wr_data = 32'hABCD; ecall = 1'b1;
        #1 rst_n = 1'b0;
        rdchk("async_rst_mepc", 12'h341, 32'h0);
        rdchk("async_rst_mscratch", 12'h340, 32'h0);
        rdchk("async_rst_mcycle", 12'hB00, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      tick();
    end
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
